// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: two-requester round-robin front end for a single
// parallel-in/serial-out shift path. Words are shifted out MSB-first.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after each word (frame length WIDTH+1 instead of WIDTH).
module piso_tx_scheduler #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             ACK0,
  output logic             ACK1,
  output logic             GNT,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SFIRST,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef PISO_TX_PARITY_EN
    ,
    S_PAR   = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_ptr;
  logic             r_gnt;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_sout;
  logic             r_svalid;
  logic             r_sfirst;
  logic             r_busy;

  state_t           w_state_n;
  logic [WIDTH-1:0] w_sreg_n;
  logic [CW-1:0]    w_cnt_n;
  logic             w_ptr_n;
  logic             w_gnt_n;
  logic             w_ack0_n;
  logic             w_ack1_n;
  logic             w_sout_n;
  logic             w_svalid_n;
  logic             w_sfirst_n;
  logic             w_busy_n;
  logic             w_accept;
  logic             w_any;
  logic             w_g;
  logic [WIDTH-1:0] w_word;

`ifdef PISO_TX_PARITY_EN
  logic             r_par;
  logic             w_par_n;
`endif

  // Arbitration: a lone requester wins outright; on contention the pointer decides.
  always_comb begin
    w_any  = REQ0 | REQ1;
    w_g    = (REQ0 & REQ1) ? r_ptr : REQ1;
    w_word = w_g ? D1 : D0;
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_n  = r_state;
    w_sreg_n   = r_sreg;
    w_cnt_n    = r_cnt;
    w_ptr_n    = r_ptr;
    w_gnt_n    = r_gnt;
    w_ack0_n   = 1'b0;
    w_ack1_n   = 1'b0;
    w_sout_n   = 1'b0;
    w_svalid_n = 1'b0;
    w_sfirst_n = 1'b0;
    w_busy_n   = 1'b0;
    w_accept   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    w_par_n    = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        w_accept = 1'b1;
      end
      S_SHIFT: begin
        w_sreg_n = r_sreg << 1;
        if (r_cnt != '0) begin
          w_cnt_n    = r_cnt - 1'b1;
          w_sout_n   = r_sreg[WIDTH-2];
          w_svalid_n = 1'b1;
          w_busy_n   = 1'b1;
        end else begin
`ifdef PISO_TX_PARITY_EN
          // LSB is on the line now; the parity bit follows in its own cycle.
          w_state_n  = S_PAR;
          w_sout_n   = r_par;
          w_svalid_n = 1'b1;
          w_busy_n   = 1'b1;
`else
          // LSB is on the line now; this edge may load the next word back-to-back.
          w_state_n  = S_IDLE;
          w_accept   = 1'b1;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      S_PAR: begin
        w_state_n = S_IDLE;
        w_accept  = 1'b1;
      end
`endif
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    if (w_accept && w_any) begin
      w_state_n  = S_SHIFT;
      w_sreg_n   = w_word;
      w_cnt_n    = CNT_MAX;
      w_gnt_n    = w_g;
      // Pointer always favours the requester that just lost or did not ask.
      w_ptr_n    = ~w_g;
      w_ack0_n   = ~w_g;
      w_ack1_n   = w_g;
      w_sout_n   = w_word[WIDTH-1];
      w_svalid_n = 1'b1;
      w_sfirst_n = 1'b1;
      w_busy_n   = 1'b1;
`ifdef PISO_TX_PARITY_EN
      w_par_n    = ^w_word;
`endif
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_ptr    <= 1'b0;
      r_gnt    <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_sout   <= 1'b0;
      r_svalid <= 1'b0;
      r_sfirst <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sreg   <= w_sreg_n;
      r_cnt    <= w_cnt_n;
      r_ptr    <= w_ptr_n;
      r_gnt    <= w_gnt_n;
      r_ack0   <= w_ack0_n;
      r_ack1   <= w_ack1_n;
      r_sout   <= w_sout_n;
      r_svalid <= w_svalid_n;
      r_sfirst <= w_sfirst_n;
      r_busy   <= w_busy_n;
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity of the word in flight, captured when the word is loaded.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_n;
    end
  end
`endif

  assign ACK0   = r_ack0;
  assign ACK1   = r_ack1;
  assign GNT    = r_gnt;
  assign SOUT   = r_sout;
  assign SVALID = r_svalid;
  assign SFIRST = r_sfirst;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Testbench for piso_tx_scheduler (WIDTH=3). Builds with or without
// PISO_TX_PARITY_EN; expected frames gain a parity bit when it is defined.
module tb_piso_tx_scheduler;

  localparam int W = 3;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         CLK;
  logic         RST_N;
  logic         REQ0;
  logic [W-1:0] D0;
  logic         REQ1;
  logic [W-1:0] D1;
  logic         ACK0;
  logic         ACK1;
  logic         GNT;
  logic         SOUT;
  logic         SVALID;
  logic         SFIRST;
  logic         BUSY;

  piso_tx_scheduler #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ0  (REQ0),
    .D0    (D0),
    .REQ1  (REQ1),
    .D1    (D1),
    .ACK0  (ACK0),
    .ACK1  (ACK1),
    .GNT   (GNT),
    .SOUT  (SOUT),
    .SVALID(SVALID),
    .SFIRST(SFIRST),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         g;
    logic [W-1:0] w;
  } frame_t;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int           n;
    logic [7:0]   gseq;
  } vec_t;

  frame_t sb[$];
  vec_t   vecs[5];
  int     n_checks = 0;
  int     n_err    = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FL-1:0] frame_bits(input logic [W-1:0] w);
`ifdef PISO_TX_PARITY_EN
    return {w, w[2] ^ w[1] ^ w[0]};
`else
    return w;
`endif
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Pops one expected frame and checks it bit by bit at negedges.
  task automatic run_frame(input bit wait_start, input bit drop, input bit glitch0);
    frame_t        f;
    logic [FL-1:0] fb;
    int            waited;
    @(negedge CLK);
    if (sb.size() == 0) begin
      chk("sb_underflow", 8'd1, 8'd0);
      return;
    end
    f      = sb.pop_front();
    fb     = frame_bits(f.w);
    waited = 0;
    if (wait_start) begin
      while (SVALID !== 1'b1 && waited < 6) begin
        @(negedge CLK);
        waited++;
      end
    end
    chk("frame_start", 8'({SVALID, SFIRST}), 8'b11);
    for (int b = 0; b < FL; b++) begin
      if (b > 0) @(negedge CLK);
      chk("sout", 8'(SOUT), 8'(fb[FL-1-b]));
      chk("svalid", 8'(SVALID), 8'd1);
      chk("sfirst", 8'(SFIRST), 8'(b == 0));
      chk("ack", 8'({ACK0, ACK1}), (b == 0) ? (f.g ? 8'b01 : 8'b10) : 8'b00);
      chk("gnt", 8'(GNT), 8'(f.g));
      chk("busy", 8'(BUSY), 8'd1);
      if (b == 0 && drop) begin
        REQ0 = 1'b0;
        REQ1 = 1'b0;
      end
      if (glitch0 && b == 1) begin
        REQ0 = 1'b1;
        D0   = 3'b111;
      end
      if (glitch0 && b == FL - 1) REQ0 = 1'b0;
    end
  endtask

  task automatic chk_idle(input string name);
    @(negedge CLK);
    chk(name, 8'({SVALID, SOUT, SFIRST, BUSY, ACK0, ACK1}), 8'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    D0    = '0;
    D1    = '0;

    // r0, r1, d0, d1, frames, grant sequence (bit f = grant of frame f)
    vecs[0] = '{1'b1, 1'b0, 3'b110, 3'b000, 1, 8'b0000};
    vecs[1] = '{1'b1, 1'b1, 3'b100, 3'b011, 4, 8'b1010};
    vecs[2] = '{1'b0, 1'b1, 3'b000, 3'b101, 3, 8'b0111};
    vecs[3] = '{1'b1, 1'b1, 3'b111, 3'b000, 2, 8'b0010};
    vecs[4] = '{1'b1, 1'b0, 3'b001, 3'b000, 2, 8'b0000};

    // Reset held two cycles, then idle with no requests.
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("reset_idle", 8'({ACK0, ACK1, GNT, SOUT, SVALID, SFIRST, BUSY}), 8'd0);
    end

    // Table-driven frames; requests drop once the last expected frame starts.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      REQ0 = vecs[i].r0;
      REQ1 = vecs[i].r1;
      D0   = vecs[i].d0;
      D1   = vecs[i].d1;
      for (int f = 0; f < vecs[i].n; f++)
        sb.push_back('{vecs[i].gseq[f], vecs[i].gseq[f] ? vecs[i].d1 : vecs[i].d0});
      for (int f = 0; f < vecs[i].n; f++)
        run_frame(f == 0, f == vecs[i].n - 1, 1'b0);
      chk_idle("after_frames");
      chk("sb_left", 8'(sb.size()), 8'd0);
    end

    // REQ0 raised and dropped mid-frame, never at an accept point: ignored.
    do_reset();
    REQ1 = 1'b1;
    D1   = 3'b101;
    sb.push_back('{1'b1, 3'b101});
    run_frame(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) chk_idle("glitch_ignored");

    // Reset during the second bit of a word, then REQ1 alone is granted.
    do_reset();
    REQ0 = 1'b1;
    D0   = 3'b011;
    @(negedge CLK);
    chk("mid_first", 8'({SFIRST, ACK0, SOUT}), 8'b110);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("mid_bit2", 8'({SVALID, SOUT}), 8'b11);
    RST_N = 1'b0;
    REQ1  = 1'b1;
    D1    = 3'b110;
    @(negedge CLK);
    chk("mid_reset", 8'({SVALID, BUSY, ACK0, ACK1, GNT}), 8'd0);
    RST_N = 1'b1;
    sb.push_back('{1'b1, 3'b110});
    run_frame(1'b0, 1'b1, 1'b0);
    chk_idle("mid_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
